// File: rtl/fir_mac_engine.sv
// Sequential FIR core: one multiply-accumulate per cycle against a registered coefficient ROM.
// Keeps a circular sample history and emits one saturated output per accepted sample.
module fir_mac_engine #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned TAPS   = 64,
  parameter int unsigned ACCW   = 40,
  parameter int unsigned SHIFT  = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DWIDTH-1:0] sample_in,
  input  logic              sample_valid,
  output logic              ready,
  output logic              coef_rd,
  output logic [31:0]       coef_addr,
  input  logic [DWIDTH-1:0] coef_data,
  output logic [DWIDTH-1:0] sample_out,
  output logic              out_valid
);

  localparam int unsigned PW    = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned PRODW = 2 * DWIDTH;

  localparam logic [PW-1:0] TAP_LAST = PW'(TAPS - 1);

  localparam logic signed [ACCW-1:0] SAT_MAX =
    {{(ACCW - DWIDTH + 1){1'b0}}, {(DWIDTH - 1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN =
    {{(ACCW - DWIDTH + 1){1'b1}}, {(DWIDTH - 1){1'b0}}};
  localparam logic [DWIDTH-1:0] OUT_MAX = {1'b0, {(DWIDTH - 1){1'b1}}};
  localparam logic [DWIDTH-1:0] OUT_MIN = {1'b1, {(DWIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [PW-1:0] tap;
  logic [PW-1:0] tap_next;
  logic          rd_next;
  logic          ready_next;

  logic [DWIDTH-1:0] hist [TAPS];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     newest;
  logic              mac_en;
  logic [PW-1:0]     mac_j;
  logic [PW-1:0]     hist_idx;

  logic signed [PRODW-1:0] prod;
  logic signed [ACCW-1:0]  acc;
  logic signed [ACCW-1:0]  acc_sum;
  logic signed [ACCW-1:0]  shifted;
  logic [DWIDTH-1:0]       sat_val;

  logic accept;

  assign accept    = (state == IDLE) && sample_valid;
  assign coef_addr = 32'(tap);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_valid) state_next = RUN;
      RUN:     if (tap == TAP_LAST) state_next = DRAIN;
      DRAIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered control outputs
  always_comb begin
    ready_next = (state_next == IDLE);
    rd_next    = 1'b0;
    tap_next   = '0;
    case (state)
      IDLE: begin
        if (sample_valid) rd_next = 1'b1;
      end
      RUN: begin
        if (tap != TAP_LAST) begin
          rd_next  = 1'b1;
          tap_next = tap + PW'(1);
        end
      end
      default: begin
        rd_next  = 1'b0;
        tap_next = '0;
      end
    endcase
  end

  // Control output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      ready   <= 1'b1;
      coef_rd <= 1'b0;
      tap     <= '0;
    end else begin
      ready   <= ready_next;
      coef_rd <= rd_next;
      tap     <= tap_next;
    end
  end

  // History index (newest - j) mod TAPS, valid for non-power-of-two TAPS
  always_comb begin
    if (newest >= mac_j) begin
      hist_idx = newest - mac_j;
    end else begin
      hist_idx = PW'({1'b0, newest} + (PW + 1)'(TAPS) - {1'b0, mac_j});
    end
  end

  // MAC datapath and output saturation
  always_comb begin
    prod    = PRODW'($signed(coef_data)) * PRODW'($signed(hist[hist_idx]));
    acc_sum = acc + (mac_en ? ACCW'(prod) : '0);
    shifted = acc_sum >>> SHIFT;
    if (shifted > SAT_MAX) begin
      sat_val = OUT_MAX;
    end else if (shifted < SAT_MIN) begin
      sat_val = OUT_MIN;
    end else begin
      sat_val = shifted[DWIDTH-1:0];
    end
  end

  // History, accumulator and output registers; MAC trails the ROM read by one cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(TAPS); i++) hist[i] <= '0;
      wr_ptr     <= '0;
      newest     <= '0;
      mac_en     <= 1'b0;
      mac_j      <= '0;
      acc        <= '0;
      sample_out <= '0;
      out_valid  <= 1'b0;
    end else begin
      mac_en    <= coef_rd;
      mac_j     <= tap;
      out_valid <= (state == DRAIN);
      if (accept) begin
        hist[wr_ptr] <= sample_in;
        newest       <= wr_ptr;
        wr_ptr       <= (wr_ptr == TAP_LAST) ? '0 : wr_ptr + PW'(1);
        acc          <= '0;
      end else if (mac_en) begin
        acc <= acc_sum;
      end
      if (state == DRAIN) sample_out <= sat_val;
    end
  end

endmodule
